// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit path (and the future receive-side FCS checker).
package gmii_pkg;

    localparam logic [7:0]  ETH_PREAMBLE      = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_POLY_REFL = 32'hEDB88320;

    // Each state names the byte being loaded into the output register this cycle.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_DROP     = 3'd5,
        ST_IFG      = 3'd6
    } tx_state_t;

    // Reflected CRC-32 advanced by one byte, data LSB first.
    function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ ETH_CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Saturating 16-bit increment, sticks at 0xFFFF.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the Ethernet CRC-32 for one data byte.
module eth_crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Fold one byte into the running CRC.
    always_comb begin
        crc_next = crc32_update_byte(crc, data);
    end

endmodule

// File: rtl/gmii_frame_tx.sv
// Byte-stream to GMII frame transmitter: preamble/SFD, payload, zero pad, FCS, inter-frame gap.
module gmii_frame_tx
    import gmii_pkg::*;
#(
    parameter int unsigned MIN_FRAME_LEN  = 64,
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned ENABLE_PADDING = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       frame_sent,
    output logic       underflow
);

    // Payload+pad byte count that leaves exactly room for the 4 FCS bytes.
    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LEN - 32'd4);
    localparam logic [15:0] IFG_LAST   = 16'(IFG_BYTES - 32'd1);
    localparam bit          PAD_EN     = (ENABLE_PADDING != 0);

    tx_state_t   state_r;
    logic [7:0]  txd_r;
    logic        tx_en_r;
    logic        tx_er_r;
    logic        frame_sent_r;
    logic        underflow_r;
    logic        bad_frame_r;
    logic [31:0] crc_r;
    logic [15:0] byte_cnt_r;
    logic [15:0] aux_cnt_r;

    logic [7:0]  crc_data_s;
    logic [31:0] crc_next_s;
    logic [15:0] cnt_inc_s;
    logic [31:0] fcs_s;
    logic [7:0]  fcs_byte_s;
    logic        tready_s;
    logic        busy_s;

    eth_crc32_d8 u_crc (
        .crc      (crc_r),
        .data     (crc_data_s),
        .crc_next (crc_next_s)
    );

    assign cnt_inc_s = sat_inc16(byte_cnt_r);
    assign fcs_s     = ~crc_r;

    // Pad bytes feed zeros into the CRC; everything else feeds the stream byte.
    always_comb begin
        crc_data_s = s_axis_tdata;
        if (state_r == ST_PAD) begin
            crc_data_s = 8'h00;
        end else begin
            crc_data_s = s_axis_tdata;
        end
    end

    // Select the FCS byte for this cycle, least-significant byte first.
    always_comb begin
        fcs_byte_s = 8'h00;
        case (aux_cnt_r[1:0])
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            2'd3:    fcs_byte_s = fcs_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Ready and busy depend on the state alone, never on tvalid.
    always_comb begin
        tready_s = 1'b0;
        case (state_r)
            ST_PAYLOAD: tready_s = 1'b1;
            ST_DROP:    tready_s = 1'b1;
            default:    tready_s = 1'b0;
        endcase
        busy_s = (state_r != ST_IDLE);
    end

    // Frame sequencer with registered GMII outputs, CRC and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            txd_r        <= 8'h00;
            tx_en_r      <= 1'b0;
            tx_er_r      <= 1'b0;
            frame_sent_r <= 1'b0;
            underflow_r  <= 1'b0;
            bad_frame_r  <= 1'b0;
            crc_r        <= ETH_CRC_INIT;
            byte_cnt_r   <= 16'd0;
            aux_cnt_r    <= 16'd0;
        end else begin
            frame_sent_r <= 1'b0;
            underflow_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r <= 16'd0;
                    aux_cnt_r  <= 16'd0;
                    tx_er_r    <= 1'b0;
                    if (s_axis_tvalid) begin
                        txd_r       <= ETH_PREAMBLE;
                        tx_en_r     <= 1'b1;
                        crc_r       <= ETH_CRC_INIT;
                        bad_frame_r <= 1'b0;
                        state_r     <= ST_PREAMBLE;
                    end else begin
                        txd_r   <= 8'h00;
                        tx_en_r <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    tx_en_r <= 1'b1;
                    tx_er_r <= 1'b0;
                    if (aux_cnt_r == 16'd6) begin
                        txd_r     <= ETH_SFD;
                        aux_cnt_r <= 16'd0;
                        state_r   <= ST_PAYLOAD;
                    end else begin
                        txd_r     <= ETH_PREAMBLE;
                        aux_cnt_r <= aux_cnt_r + 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    tx_en_r <= 1'b1;
                    if (s_axis_tvalid) begin
                        txd_r      <= s_axis_tdata;
                        tx_er_r    <= 1'b0;
                        crc_r      <= crc_next_s;
                        byte_cnt_r <= cnt_inc_s;
                        aux_cnt_r  <= 16'd0;
                        if (s_axis_tlast) begin
                            bad_frame_r <= s_axis_tuser;
                            if (PAD_EN && (cnt_inc_s < PAD_TARGET)) begin
                                state_r <= ST_PAD;
                            end else begin
                                state_r <= ST_FCS;
                            end
                        end
                    end else begin
                        // Starved mid-frame: repeat the last byte flagged as an error, then abandon.
                        tx_er_r     <= 1'b1;
                        underflow_r <= 1'b1;
                        state_r     <= ST_DROP;
                    end
                end
                ST_PAD: begin
                    txd_r      <= 8'h00;
                    tx_en_r    <= 1'b1;
                    tx_er_r    <= 1'b0;
                    crc_r      <= crc_next_s;
                    byte_cnt_r <= cnt_inc_s;
                    if (cnt_inc_s >= PAD_TARGET) begin
                        aux_cnt_r <= 16'd0;
                        state_r   <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    txd_r   <= fcs_byte_s;
                    tx_en_r <= 1'b1;
                    tx_er_r <= bad_frame_r;
                    if (aux_cnt_r == 16'd3) begin
                        frame_sent_r <= 1'b1;
                        aux_cnt_r    <= 16'd0;
                        state_r      <= ST_IFG;
                    end else begin
                        aux_cnt_r <= aux_cnt_r + 16'd1;
                    end
                end
                ST_DROP: begin
                    txd_r   <= 8'h00;
                    tx_en_r <= 1'b0;
                    tx_er_r <= 1'b0;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        aux_cnt_r <= 16'd0;
                        state_r   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    txd_r   <= 8'h00;
                    tx_en_r <= 1'b0;
                    tx_er_r <= 1'b0;
                    if (aux_cnt_r >= IFG_LAST) begin
                        aux_cnt_r <= 16'd0;
                        state_r   <= ST_IDLE;
                    end else begin
                        aux_cnt_r <= aux_cnt_r + 16'd1;
                    end
                end
                default: begin
                    txd_r     <= 8'h00;
                    tx_en_r   <= 1'b0;
                    tx_er_r   <= 1'b0;
                    aux_cnt_r <= 16'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign gmii_txd      = txd_r;
    assign gmii_tx_en    = tx_en_r;
    assign gmii_tx_er    = tx_er_r;
    assign frame_sent    = frame_sent_r;
    assign underflow     = underflow_r;
    assign s_axis_tready = tready_s;
    assign busy          = busy_s;

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: padded and unpadded instances, line-level capture.
module tb_gmii_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, sel;

    logic [7:0] txd_a, txd_b;
    logic       en_a, er_a, rdy_a, busy_a, sent_a, uf_a;
    logic       en_b, er_b, rdy_b, busy_b, sent_b, uf_b;
    logic       tvalid_a, tvalid_b;

    logic [7:0] m_txd;
    logic       m_en, m_er, m_rdy, m_busy, m_sent, m_uf;

    int total, bad;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cap_d[$];
    logic       cap_e[$];
    int         gap_q[$];
    int         sent_cnt, sent_idx, uf_cnt, er_cnt, idle_run;
    bit         seen_en, mon_on;

    always #4 clk = ~clk;

    assign tvalid_a = tvalid & ~sel;
    assign tvalid_b = tvalid & sel;

    gmii_frame_tx #(.MIN_FRAME_LEN(64), .IFG_BYTES(12), .ENABLE_PADDING(1)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_a),
        .s_axis_tready(rdy_a), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_a), .gmii_tx_en(en_a), .gmii_tx_er(er_a),
        .busy(busy_a), .frame_sent(sent_a), .underflow(uf_a)
    );

    gmii_frame_tx #(.MIN_FRAME_LEN(64), .IFG_BYTES(12), .ENABLE_PADDING(0)) dut_np (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_b),
        .s_axis_tready(rdy_b), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_b), .gmii_tx_en(en_b), .gmii_tx_er(er_b),
        .busy(busy_b), .frame_sent(sent_b), .underflow(uf_b)
    );

    assign m_txd  = sel ? txd_b  : txd_a;
    assign m_en   = sel ? en_b   : en_a;
    assign m_er   = sel ? er_b   : er_a;
    assign m_rdy  = sel ? rdy_b  : rdy_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_sent = sel ? sent_b : sent_a;
    assign m_uf   = sel ? uf_b   : uf_a;

    // Line monitor on the selected instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (m_en) begin
                if (seen_en && idle_run > 0) gap_q.push_back(idle_run);
                seen_en  = 1'b1;
                idle_run = 0;
                cap_d.push_back(m_txd);
                cap_e.push_back(m_er);
            end else if (seen_en) begin
                idle_run++;
            end
            if (m_er) er_cnt++;
            if (m_sent) begin
                sent_cnt++;
                sent_idx = cap_d.size();
            end
            if (m_uf) uf_cnt++;
        end
    end

    // Reference FCS: bit-serial LSB-first CRC-32, complemented.
    function automatic logic [31:0] ref_fcs(input logic [7:0] d[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[k][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Expected line bytes for pay_q: preamble, SFD, payload, optional pad, FCS.
    task automatic build_expected(input bit pad_en);
        logic [7:0]  fr[$];
        logic [31:0] fcs;
        fr = pay_q;
        if (pad_en) while (fr.size() < 60) fr.push_back(8'h00);
        fcs = ref_fcs(fr);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (fr[k]) exp_q.push_back(fr[k]);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        cap_d.delete(); cap_e.delete(); gap_q.delete();
        sent_cnt = 0; sent_idx = 0; uf_cnt = 0; er_cnt = 0; idle_run = 0;
        seen_en = 1'b0;
        mon_on  = 1'b1;
    endtask

    // Stream pay_q[0..n-1]; optionally withhold tvalid for one ready cycle at byte gap_at.
    task automatic drive_frame(input int n, input bit user, input int gap_at);
        int i, cyc;
        bit gap_done, rdy;
        i = 0; cyc = 0; gap_done = 1'b0;
        while (i < n && cyc < 3000) begin
            @(negedge clk);
            rdy = m_rdy;
            if (gap_at >= 0 && i == gap_at && rdy && !gap_done) begin
                tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                gap_done = 1'b1;
            end else begin
                tvalid = 1'b1;
                tdata  = pay_q[i];
                tlast  = (i == n - 1);
                tuser  = user && (i == n - 1);
            end
            @(posedge clk);
            if (rdy && tvalid) i++;
            cyc++;
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        total++;
        if (i != n) begin bad++; $display("FAIL drive_timeout: accepted %0d of %0d bytes", i, n); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (en_a !== 1'b0)    begin bad++; $display("FAIL reset_tx_en: got %b want 0", en_a); end
        total++; if (txd_a !== 8'h00)  begin bad++; $display("FAIL reset_txd: got %h want 00", txd_a); end
        total++; if (er_a !== 1'b0)    begin bad++; $display("FAIL reset_tx_er: got %b want 0", er_a); end
        total++; if (rdy_a !== 1'b0)   begin bad++; $display("FAIL reset_tready: got %b want 0", rdy_a); end
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        total++; if (sent_a !== 1'b0)  begin bad++; $display("FAIL reset_frame_sent: got %b want 0", sent_a); end
        total++; if (uf_a !== 1'b0)    begin bad++; $display("FAIL reset_underflow: got %b want 0", uf_a); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy_a !== 1'b0 || en_a !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busy_a, en_a); end
    endtask

    task automatic test_frame_60();
        logic [7:0] got;
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 60; i++) pay_q.push_back(8'(i));
        clear_mon();
        drive_frame(60, 1'b0, -1);
        repeat (40) @(negedge clk);
        build_expected(1'b1);
        total++; if (cap_d.size() != 72) begin bad++; $display("FAIL f60_en_cycles: got %0d want 72", cap_d.size()); end
        for (int i = 0; i < 72; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 8'hxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL f60_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (sent_cnt != 1 || sent_idx != 72) begin bad++; $display("FAIL f60_frame_sent: pulses=%0d at byte %0d want 1 at 72", sent_cnt, sent_idx); end
        total++; if (er_cnt != 0 || uf_cnt != 0) begin bad++; $display("FAIL f60_errors: er=%0d uf=%0d want 0 0", er_cnt, uf_cnt); end
        total++; if (gap_q.size() != 0) begin bad++; $display("FAIL f60_tx_en_continuous: gaps=%0d want 0", gap_q.size()); end
    endtask

    task automatic test_crc_check();
        logic [7:0] got;
        logic [7:0] fcs_exp[4];
        fcs_exp[0] = 8'h26; fcs_exp[1] = 8'h39; fcs_exp[2] = 8'hF4; fcs_exp[3] = 8'hCB;
        sel = 1'b1;
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
        clear_mon();
        drive_frame(9, 1'b0, -1);
        repeat (40) @(negedge clk);
        total++; if (cap_d.size() != 21) begin bad++; $display("FAIL crc_len: got %0d want 21", cap_d.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (17 + k < cap_d.size()) ? cap_d[17 + k] : 8'hxx;
            total++; if (got !== fcs_exp[k]) begin bad++; $display("FAIL crc_fcs[%0d]: got %h want %h", k, got, fcs_exp[k]); end
        end
        total++; if (sent_cnt != 1 || sent_idx != 21) begin bad++; $display("FAIL crc_frame_sent: pulses=%0d at byte %0d want 1 at 21", sent_cnt, sent_idx); end
        sel = 1'b0;
    endtask

    task automatic test_padding();
        logic [7:0] got;
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'(8'hA0 + i));
        clear_mon();
        drive_frame(10, 1'b0, -1);
        repeat (100) @(negedge clk);
        build_expected(1'b1);
        total++; if (cap_d.size() != 72) begin bad++; $display("FAIL pad_len_after_sfd: got %0d want 64", cap_d.size() - 8); end
        for (int i = 0; i < 72; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 8'hxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL pad_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (sent_cnt != 1 || sent_idx != 72) begin bad++; $display("FAIL pad_frame_sent: pulses=%0d at byte %0d want 1 at 72", sent_cnt, sent_idx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 60; i++) pay_q.push_back(8'(i * 7 + 3));
        clear_mon();
        drive_frame(60, 1'b0, -1);
        drive_frame(60, 1'b0, -1);
        repeat (60) @(negedge clk);
        build_expected(1'b1);
        total++; if (gap_q.size() != 1) begin bad++; $display("FAIL b2b_gap_count: got %0d want 1", gap_q.size()); end
        total++; if (gap_q.size() < 1 || gap_q[0] != 12) begin bad++; $display("FAIL b2b_ifg: got %0d want 12", (gap_q.size() > 0) ? gap_q[0] : -1); end
        total++; if (cap_d.size() != 144 || sent_cnt != 2) begin bad++; $display("FAIL b2b_totals: bytes=%0d sent=%0d want 144 2", cap_d.size(), sent_cnt); end
        for (int i = 0; i < 144; i++) begin
            got = (i < cap_d.size()) ? cap_d[i] : 8'hxx;
            total++; if (got !== exp_q[i % 72]) begin bad++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, got, exp_q[i % 72]); end
        end
    endtask

    task automatic test_underflow();
        logic [7:0] got, want;
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 40; i++) pay_q.push_back(8'(8'h10 + i));
        clear_mon();
        drive_frame(40, 1'b0, 20);
        total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL uf_ifg_entry: busy=%b want 1", m_busy); end
        repeat (11) @(negedge clk);
        total++; if (m_busy !== 1'b1 || m_en !== 1'b0) begin bad++; $display("FAIL uf_ifg_hold: busy=%b en=%b want 1 0", m_busy, m_en); end
        @(negedge clk);
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL uf_ifg_end: busy=%b want 0", m_busy); end
        repeat (5) @(negedge clk);
        total++; if (cap_d.size() != 29) begin bad++; $display("FAIL uf_len: got %0d want 29", cap_d.size()); end
        for (int j = 0; j < 28; j++) begin
            want = (j < 7) ? 8'h55 : ((j == 7) ? 8'hD5 : pay_q[j - 8]);
            got  = (j < cap_d.size()) ? cap_d[j] : 8'hxx;
            total++; if (got !== want) begin bad++; $display("FAIL uf_byte[%0d]: got %h want %h", j, got, want); end
        end
        got = (cap_d.size() > 28) ? cap_d[28] : 8'hxx;
        total++; if (got !== pay_q[19] || cap_e.size() < 29 || cap_e[28] !== 1'b1) begin bad++; $display("FAIL uf_err_byte: got %h want %h with tx_er", got, pay_q[19]); end
        total++; if (uf_cnt != 1 || er_cnt != 1) begin bad++; $display("FAIL uf_pulse: uf=%0d er=%0d want 1 1", uf_cnt, er_cnt); end
        total++; if (sent_cnt != 0) begin bad++; $display("FAIL uf_no_fcs: frame_sent=%0d want 0", sent_cnt); end
    endtask

    task automatic test_tuser();
        logic [7:0] got;
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 60; i++) pay_q.push_back(8'(8'hFF - i));
        clear_mon();
        drive_frame(60, 1'b1, -1);
        repeat (40) @(negedge clk);
        build_expected(1'b1);
        total++; if (er_cnt != 4) begin bad++; $display("FAIL tuser_er_count: got %0d want 4", er_cnt); end
        for (int k = 68; k < 72; k++) begin
            got = (k < cap_d.size()) ? cap_d[k] : 8'hxx;
            total++; if (got !== exp_q[k] || k >= cap_e.size() || cap_e[k] !== 1'b1) begin bad++; $display("FAIL tuser_fcs[%0d]: got %h want %h with tx_er", k - 68, got, exp_q[k]); end
        end
        total++; if (sent_cnt != 1) begin bad++; $display("FAIL tuser_frame_sent: got %0d want 1", sent_cnt); end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        clear_mon();
        @(negedge clk);
        tvalid = 1'b1; tdata = 8'h77; tlast = 1'b0; tuser = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (m_en !== 1'b1 || m_busy !== 1'b1) begin bad++; $display("FAIL rstmid_active: en=%b busy=%b want 1 1", m_en, m_busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (en_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_drop: en=%b busy=%b want 0 0", en_a, busy_a); end
        total++; if (rdy_a !== 1'b0 || txd_a !== 8'h00) begin bad++; $display("FAIL rstmid_outputs: tready=%b txd=%h want 0 00", rdy_a, txd_a); end
        tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (sent_cnt != 0 || uf_cnt != 0 || en_a !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: sent=%0d uf=%0d en=%b want 0 0 0", sent_cnt, uf_cnt, en_a); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; sel = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
        mon_on = 1'b0; seen_en = 1'b0;
        sent_cnt = 0; sent_idx = 0; uf_cnt = 0; er_cnt = 0; idle_run = 0;
        test_reset();
        test_frame_60();
        test_crc_check();
        test_padding();
        test_back_to_back();
        test_underflow();
        test_tuser();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
